// File: rtl/gb_pkg.sv
// gb_pkg: SNES button bit indices, scanner FSM states and poll-period helper
package gb_pkg;
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} snes_state_e;
  function automatic int snes_eff_period(input int poll, input int div);
    return (poll > 34 * div) ? poll : 34 * div + 1;
  endfunction
endpackage

// File: rtl/snes_pad_channel.sv
// snes_pad_channel: one pad's shift register, debounce and commit (in: clock, rst, shift_i, data_i, commit_i; out: buttons_o, press_o)
module snes_pad_channel
  import gb_pkg::*;
#(
  parameter bit DEBOUNCE = 1'b1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        shift_i,
  input  logic        data_i,
  input  logic        commit_i,
  output logic [15:0] buttons_o,
  output logic        press_o
);
  logic [15:0] sr_q, prev_q, btn_q, btn_d;
  assign btn_d = (!DEBOUNCE || sr_q == prev_q) ? sr_q : btn_q;
  assign press_o = commit_i && |(btn_d & ~btn_q);
  assign buttons_o = btn_q;
  always_ff @(posedge clock) begin
    if (rst) begin
      sr_q <= '0;
      prev_q <= '0;
      btn_q <= '0;
    end else begin
      if (shift_i) sr_q <= {~data_i, sr_q[15:1]};
      if (commit_i) begin
        prev_q <= sr_q;
        btn_q <= btn_d;
      end
    end
  end
endmodule

// File: rtl/snes_pad_scanner.sv
// snes_pad_scanner: polls N_PADS SNES pads (in: clock, rst, enable, snes_data; out: snes_latch, snes_clock, buttons, frame_done, press_irq)
module snes_pad_scanner
  import gb_pkg::*;
#(
  parameter int unsigned N_PADS      = 2,
  parameter int unsigned CLK_DIV     = 24,
  parameter int unsigned POLL_PERIOD = 70000,
  parameter bit          DEBOUNCE    = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_PADS-1:0]     snes_data,
  output logic                  snes_latch,
  output logic                  snes_clock,
  output logic [16*N_PADS-1:0]  buttons,
  output logic                  frame_done,
  output logic                  press_irq
);
  localparam int EFF = snes_eff_period(int'(POLL_PERIOD), int'(CLK_DIV));
  localparam int PW = $clog2(EFF);
  localparam int HW = $clog2(2 * CLK_DIV);
  snes_state_e state_q;
  logic [PW-1:0] poll_q;
  logic [HW-1:0] ph_q;
  logic [3:0] pulse_q;
  logic pend_q, latch_q, sclk_q, done_q, irq_q;
  logic [N_PADS-1:0] press;
  logic wrap, go, ph_end, shift, commit;
  assign wrap = poll_q == PW'(EFF - 1);
  assign go = state_q == IDLE && enable && (wrap || pend_q);
  assign ph_end = ph_q == '0;
  // 16 samples per frame: bit 0 at latch end, bits 1..15 at HIGH ends; the 16th pulse is dropped
  assign shift = ph_end && (state_q == LATCH || (state_q == HIGH && pulse_q != 4'd15));
  assign commit = state_q == DONE;
  assign snes_latch = latch_q;
  assign snes_clock = sclk_q;
  assign frame_done = done_q;
  assign press_irq = irq_q;
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      poll_q <= '0;
      ph_q <= '0;
      pulse_q <= '0;
      pend_q <= 1'b0;
      latch_q <= 1'b0;
      sclk_q <= 1'b1;
      done_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      poll_q <= wrap ? '0 : poll_q + 1'b1;
      // a wrap that lands mid-frame waits here; dropping enable discards it
      pend_q <= enable && state_q != IDLE && (pend_q || wrap);
      done_q <= 1'b0;
      irq_q <= commit && |press;
      ph_q <= ph_q - 1'b1;
      case (state_q)
        IDLE: if (go) begin
          state_q <= LATCH;
          latch_q <= 1'b1;
          ph_q <= HW'(2 * CLK_DIV - 1);
        end
        LATCH: if (ph_end) begin
          state_q <= LOW;
          latch_q <= 1'b0;
          sclk_q <= 1'b0;
          ph_q <= HW'(CLK_DIV - 1);
          pulse_q <= '0;
        end
        LOW: if (ph_end) begin
          state_q <= HIGH;
          sclk_q <= 1'b1;
          ph_q <= HW'(CLK_DIV - 1);
        end
        HIGH: if (ph_end) begin
          if (pulse_q == 4'd15) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end else begin
            state_q <= LOW;
            sclk_q <= 1'b0;
            ph_q <= HW'(CLK_DIV - 1);
            pulse_q <= pulse_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    snes_pad_channel #(.DEBOUNCE(DEBOUNCE)) u_ch (
      .clock(clock),
      .rst(rst),
      .shift_i(shift),
      .data_i(snes_data[p]),
      .commit_i(commit),
      .buttons_o(buttons[16*p +: 16]),
      .press_o(press[p])
    );
  end
endmodule
